line_fifo_mc: RTL and testbench

- Next-generation line-buffer FIFO for the HOG sliding-window front end.
- Delays a stream of multi-channel pixels by exactly one image line.
- Line length is set at run time, so one bitstream serves several frame widths.
- Output uses a registered, back-pressure-safe valid/ready stage, and each output word carries a kernel border flag.
- Several instances chain to form the K-1 line delays feeding the window/gradient stage.

---
 rtl/line_fifo_mc.sv | 179 +++++++++++++++++
 tb/tb_line_fifo_mc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fifo_mc.sv
// One-line delay FIFO for multi-channel pixels with run-time line length,
// a registered valid/ready output stage and a kernel border flag.
// Optional level/len_active ports are enabled by defining LINE_FIFO_LEVEL_EN.
module line_fifo_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 1,
  parameter int MAX_DEPTH    = 1024,
  parameter int KERNEL_WIDTH = 3,
  parameter int ADDR_WIDTH   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [ADDR_WIDTH-1:0]          line_len,
  input  logic [DATA_WIDTH*CHANNELS-1:0] w_data,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [DATA_WIDTH*CHANNELS-1:0] r_data,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic                           fifo_full,
  output logic                           border_flag
`ifdef LINE_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH-1:0]          level,
  output logic [ADDR_WIDTH-1:0]          len_active
`endif
);

  localparam int W      = DATA_WIDTH * CHANNELS;
  localparam int MEM_AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] MIN_LEN     = ADDR_WIDTH'(KERNEL_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN     = ADDR_WIDTH'(MAX_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BORDER_COLS = ADDR_WIDTH'(KERNEL_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE         = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0]   out_col_q, out_col_d;
  logic                    fifo_full_q, fifo_full_d;
  logic                    r_valid_q, r_valid_d;

  logic [ADDR_WIDTH-1:0]   len_in;
  logic [ADDR_WIDTH-1:0]   len_eff;
  logic [ADDR_WIDTH-1:0]   addr_last;
  logic                    wr;
  logic                    load;

  logic [W-1:0]            mem [MAX_DEPTH];
  logic [W-1:0]            mem_rd_q;

  // Clamp the requested length into the range the kernel and memory support.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    len_in = line_len;
    if (line_len < MIN_LEN) begin
      len_in = MIN_LEN;
    end else if (line_len > MAX_LEN) begin
      len_in = MAX_LEN;
    end
  end

  assign len_eff   = (state_q == S_IDLE) ? len_in : len_q;
  assign addr_last = len_eff - ONE;

  assign w_ready = !fifo_full_q || !r_valid_q || r_ready;
  assign wr      = w_valid && w_ready && !clear;
  assign load    = wr && (state_q == S_STREAM);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    w_addr_d    = w_addr_q;
    out_col_d   = out_col_q;
    fifo_full_d = fifo_full_q;
    r_valid_d   = r_valid_q;

    if (clear) begin
      state_d     = S_IDLE;
      len_d       = '0;
      w_addr_d    = '0;
      out_col_d   = '0;
      fifo_full_d = 1'b0;
      r_valid_d   = 1'b0;
    end else begin
      if (r_valid_q && r_ready) begin
        r_valid_d = 1'b0;
      end
      if (wr) begin
        w_addr_d = (w_addr_q == addr_last) ? '0 : w_addr_q + ONE;
        case (state_q)
          S_IDLE, S_FILL: begin
            len_d = len_eff;
            if (w_addr_q == addr_last) begin
              state_d     = S_STREAM;
              fifo_full_d = 1'b1;
            end else begin
              state_d = S_FILL;
            end
          end
          default: begin
            // The word read out was written at this address, so its column is the address.
            r_valid_d = 1'b1;
            out_col_d = w_addr_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      w_addr_q    <= '0;
      out_col_q   <= '0;
      fifo_full_q <= 1'b0;
      r_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      w_addr_q    <= w_addr_d;
      out_col_q   <= out_col_d;
      fifo_full_q <= fifo_full_d;
      r_valid_q   <= r_valid_d;
    end
  end

  // NOTE: the storage array and its read register carry no reset so they map onto block RAM;
  // r_data is masked with r_valid to give a clean zero after reset or clear.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[w_addr_q[MEM_AW-1:0]] <= w_data;
    end
    if (load) begin
      mem_rd_q <= mem[w_addr_q[MEM_AW-1:0]];
    end
  end

  assign r_data      = r_valid_q ? mem_rd_q : '0;
  assign r_valid     = r_valid_q;
  assign fifo_full   = fifo_full_q;
  assign border_flag = r_valid_q && (out_col_q < BORDER_COLS);

`ifdef LINE_FIFO_LEVEL_EN
  logic [ADDR_WIDTH-1:0] level_q, level_d;

  // Once streaming, every write stores one word and emits one, so the level stays at len_q.
  always_comb begin
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else if (wr && (state_q != S_STREAM)) begin
      level_d = level_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level      = level_q;
  assign len_active = len_q;
`endif

endmodule

// File: tb/tb_line_fifo_mc.sv
// Scoreboard bench for line_fifo_mc: the driver models the line delay and queues
// expected outputs; an independent monitor pops and compares on each r_valid/r_ready.
module tb_line_fifo_mc;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int MD = 1024;
  localparam int KW = 3;
  localparam int AW = $clog2(MD + 1);
  localparam int W  = DW * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [AW-1:0] line_len;
  logic [W-1:0]  w_data;
  logic          w_valid;
  logic          w_ready;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_ready;
  logic          fifo_full;
  logic          border_flag;

  always #5 clk = ~clk;

  line_fifo_mc #(
    .DATA_WIDTH  (DW),
    .CHANNELS    (CH),
    .MAX_DEPTH   (MD),
    .KERNEL_WIDTH(KW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .line_len   (line_len),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .fifo_full  (fifo_full),
    .border_flag(border_flag)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         flag;
  } exp_t;

  int           checks    = 0;
  int           failures  = 0;
  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  int           len_m     = 0;
  logic         rv_exp    = 1'b0;
  int           flush_cnt = 0;
  int           k         = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gen(input int idx);
    logic [7:0] a;
    a = 8'(idx);
    return {a, a + 8'd1, a + 8'd2};
  endfunction

  function automatic int clamp_len(input int l);
    if (l < KW) return KW;
    if (l > MD) return MD;
    return l;
  endfunction

  // One clock of stimulus; status is checked against the model at the falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic rr,
                       input logic clr, output logic acc);
    logic full_m;
    logic produced;
    int   n;
    produced = 1'b0;
    w_valid  = v;
    w_data   = d;
    r_ready  = rr;
    clear    = clr;
    @(negedge clk);
    full_m = (hist.size() != 0) && (hist.size() >= len_m);
    check("r_valid", r_valid, rv_exp);
    check("fifo_full", fifo_full, full_m);
    check("w_ready", w_ready, !full_m || !rv_exp || rr);
    if (!rv_exp) check("border_idle", border_flag, 0);
    acc = v && w_ready && !clr;
    if (clr) begin
      hist.delete();
      rv_exp = 1'b0;
    end else begin
      if (acc) begin
        n = hist.size();
        if (n == 0) len_m = clamp_len(int'(line_len));
        if (n >= len_m) begin
          exp_q.push_back('{hist[n-len_m], (((n - len_m) % len_m) < KW - 1)});
          produced = 1'b1;
        end
        hist.push_back(d);
      end
      rv_exp = produced || (rv_exp && !rr);
    end
    @(posedge clk);
    #1;
    if (clr) exp_q.delete();
  endtask

  task automatic write_words(input int n);
    int   done;
    logic acc;
    done = 0;
    for (int c = 0; c < n * 2 + 8 && done < n; c++) begin
      cycle(1'b1, gen(k), 1'b1, 1'b0, acc);
      if (acc) begin
        k++;
        done++;
      end
    end
    if (done != n) check("write_budget", done, n);
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic flush();
    logic acc;
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    k = 1;
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_r_valid", r_valid, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_border", border_flag, 0);
    hist.delete();
    exp_q.delete();
    rv_exp = 1'b0;
    flush_cnt++;
    w_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 1;
  endtask

  // Monitor: compares each transferred word and checks that a stalled word stays put.
  logic         held_valid = 1'b0;
  logic [W-1:0] held_data;
  int           held_flush = 0;

  always @(negedge clk) begin
    exp_t e;
    if (held_valid && held_flush == flush_cnt) begin
      check("hold_valid", r_valid, 1);
      check("hold_data", r_data, held_data);
    end
    if (r_valid && r_ready) begin
      if (exp_q.size() == 0) begin
        check("out_count", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("r_data", r_data, e.data);
        check("border_flag", border_flag, e.flag);
      end
    end
    held_valid = r_valid && !r_ready && !clear && !rst;
    held_data  = r_data;
    held_flush = flush_cnt;
  end

  initial begin
    logic acc;
    rst      = 1'b1;
    clear    = 1'b0;
    line_len = '0;
    w_data   = '0;
    w_valid  = 1'b0;
    r_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_r_valid", r_valid, 0);
    check("reset_r_data", r_data, 0);
    check("reset_fifo_full", fifo_full, 0);
    check("reset_border", border_flag, 0);
    check("reset_w_ready", w_ready, 1);
    rst = 1'b0;

    // Basic delay with line_len=5, then a 4-cycle downstream stall.
    line_len = AW'(5);
    write_words(5);
    check("fill_quiet", r_valid, 0);
    write_words(1);
    check("first_out", r_data, 24'h010203);
    write_words(4);
    check("pre_stall", r_data, gen(5));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, gen(k), 1'b0, 1'b0, acc);
      if (acc) k++;
      if (i < 3) begin
        check("stall_w_ready", w_ready, 0);
        check("stall_data", r_data, gen(5));
      end
    end
    write_words(8);
    drain();

    // Short length clamps up to the kernel width.
    flush();
    line_len = AW'(1);
    write_words(3);
    check("clamp3_fill", r_valid, 0);
    write_words(1);
    check("clamp3_first", r_data, 24'h010203);
    write_words(6);
    drain();

    // Oversized length clamps down to the memory depth.
    flush();
    line_len = AW'(2000);
    write_words(1023);
    check("clamp1024_not_full", fifo_full, 0);
    write_words(1);
    check("clamp1024_full", fifo_full, 1);
    check("clamp1024_quiet", r_valid, 0);
    write_words(1);
    check("clamp1024_first", r_data, 24'h010203);
    write_words(5);
    drain();

    // Border flag over three lines of length 8.
    flush();
    line_len = AW'(8);
    write_words(9);
    check("border_col0", border_flag, 1);
    write_words(2);
    check("border_col2", border_flag, 0);
    write_words(13);
    drain();

    // clear in FILL drops the coincident write; a new length applies afterwards.
    flush();
    line_len = AW'(6);
    write_words(3);
    cycle(1'b1, gen(k), 1'b1, 1'b1, acc);
    check("clear_fifo_full", fifo_full, 0);
    check("clear_r_valid", r_valid, 0);
    k = 1;
    line_len = AW'(4);
    write_words(4);
    check("newlen_quiet", r_valid, 0);
    write_words(1);
    check("newlen_first", r_data, 24'h010203);
    write_words(5);
    drain();

    // Asynchronous reset while streaming, then a full refill.
    flush();
    line_len = AW'(5);
    write_words(6);
    check("pre_reset_valid", r_valid, 1);
    mid_reset();
    write_words(5);
    check("refill_quiet", r_valid, 0);
    write_words(1);
    check("refill_first", r_data, 24'h010203);
    write_words(3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
